// File: rtl/score_seg_display.sv
// Score display stage: binary score -> BCD (multi-cycle double-dabble, saturating at 9999),
// then a 4-digit multiplexed 7-segment scanner with leading-zero blanking and an overflow dp.
module score_seg_display #(
  parameter int SCAN_DIV = 50000,
  parameter int SCORE_W  = 14
) (
  input  logic               board_clk,
  input  logic               rst_btn,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               ovf,
  output logic [3:0]         AN,
  output logic [7:0]         SEG
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(9999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ovf_nx_q, ovf_nx_d;
  logic [SCORE_W-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [15:0]        disp_bcd_q, disp_bcd_d;
  logic               disp_ovf_q, disp_ovf_d;

  logic               load;
  logic [SCORE_W-1:0] load_val;
  logic [15:0]        bcd_adj;

  always_comb begin
    for (int n = 0; n < 4; n++)
      bcd_adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3 : bcd_q[n*4 +: 4];
  end

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    ovf_nx_d   = ovf_nx_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    load       = 1'b0;
    load_val   = score;
    case (state_q)
      IDLE: begin
        if (score_valid) load = 1'b1;
      end
      SHIFT: begin
        // Saturated value fits in 14 bits, so bit 13 is the MSB feeding the BCD side.
        bcd_d = {bcd_adj[14:0], bin_q[13]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = DONE;
        if (score_valid) begin
          pend_d     = score;
          pend_vld_d = 1'b1;
        end
      end
      DONE: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_nx_q;
        if (score_valid) begin
          load       = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          load       = 1'b1;
          load_val   = pend_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      bin_d    = (load_val > LIMIT) ? LIMIT : load_val;
      ovf_nx_d = (load_val > LIMIT);
      bcd_d    = '0;
      cnt_d    = '0;
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge board_clk) begin
    if (!rst_btn) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_nx_q   <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      ovf_nx_q   <= ovf_nx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign ovf  = disp_ovf_q;

  // Scanner: free-running, independent of the converter.
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig;
  logic          blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;  4'd1: seg7 = 7'h79;  4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;  4'd4: seg7 = 7'h19;  4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;  4'd7: seg7 = 7'h78;  4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;  default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    scan_d = scan_q + CW'(1);
    idx_d  = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    dig = disp_bcd_q[idx_q*4 +: 4];
    case (idx_q)
      2'd3:    blank = (disp_bcd_q[15:12] == 4'd0);
      2'd2:    blank = (disp_bcd_q[15:8]  == 8'd0);
      2'd1:    blank = (disp_bcd_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 8'hFF : {~(disp_ovf_q && idx_q == 2'd3), seg7(dig)};
  end

  always_ff @(posedge board_clk) begin
    if (!rst_btn) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
endmodule

// File: tb/tb_score_seg_display.sv
// Directed bench for score_seg_display with a short scan period.
module tb_score_seg_display;
  localparam int SCAN_DIV = 4;
  localparam int SCORE_W  = 14;

  logic               clk = 1'b0;
  logic               rst_btn;
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic               busy, ovf;
  logic [3:0]         AN;
  logic [7:0]         SEG;

  int tests = 0;
  int fails = 0;

  score_seg_display #(.SCAN_DIV(SCAN_DIV), .SCORE_W(SCORE_W)) dut (
    .board_clk(clk), .rst_btn(rst_btn), .score(score), .score_valid(score_valid),
    .busy(busy), .ovf(ovf), .AN(AN), .SEG(SEG)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe at the next edge (edge k); returns just after edge k.
  task automatic strobe(input int v);
    score       = SCORE_W'(v);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  // Wait (bounded) until digit i is being driven, return its SEG value.
  task automatic get_digit(input int i, output logic [7:0] seg, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << i);
    ok   = 1'b0;
    seg  = 8'hxx;
    for (int c = 0; c < 40; c++) begin
      if (AN === want) begin
        ok  = 1'b1;
        seg = SEG;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_digits(input string name, input logic [7:0] e3, e2, e1, e0);
    logic [7:0] exp_seg [4];
    logic [7:0] s;
    bit ok;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int i = 0; i < 4; i++) begin
      get_digit(i, s, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s digit%0d: AN never selected it (got AN=%b)", name, i, AN);
      end else if (s !== exp_seg[i]) begin
        fails++;
        $display("FAIL %s digit%0d: SEG=%h expected %h", name, i, s, exp_seg[i]);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 100) begin
      tick();
      c++;
    end
    if (busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL %s: busy stuck, busy=%b expected 0", name, busy);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_btn = 1'b0;
    score = '0;
    score_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (AN !== 4'hF || SEG !== 8'hFF || busy !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: AN=%b SEG=%h busy=%b ovf=%b expected 1111 FF 0 0", AN, SEG, busy, ovf);
    end
    rst_btn = 1'b1;
    tick();
    tests++;
    if (AN !== 4'b1110 || SEG !== 8'hC0) begin
      fails++;
      $display("FAIL reset_first_edge: AN=%b SEG=%h expected 1110 C0", AN, SEG);
    end
    chk_digits("reset_blank", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
  endtask

  task automatic test_convert_1234();
    bit busy_ok;
    strobe(1234);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: busy=%b expected 1", busy);
    end
    busy_ok = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (busy !== 1'b1 || dut.disp_bcd_q !== 16'h0000) busy_ok = 1'b0;
    end
    tests++;
    if (!busy_ok) begin
      fails++;
      $display("FAIL latency_hold: busy=%b disp=%h expected busy=1 disp=0000 through k+14", busy, dut.disp_bcd_q);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || dut.disp_bcd_q !== 16'h1234 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL latency_commit: busy=%b disp=%h ovf=%b expected 0 1234 0", busy, dut.disp_bcd_q, ovf);
    end
    tick();
    chk_digits("show_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
  endtask

  task automatic test_blanking();
    strobe(7);
    wait_idle("conv_7");
    chk_digits("show_7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    strobe(1005);
    wait_idle("conv_1005");
    chk_digits("show_1005", 8'hF9, 8'hC0, 8'hC0, 8'h92);
  endtask

  task automatic test_saturate();
    strobe(12000);
    wait_idle("conv_12000");
    tests++;
    if (ovf !== 1'b1 || dut.disp_bcd_q !== 16'h9999) begin
      fails++;
      $display("FAIL saturate: ovf=%b disp=%h expected 1 9999", ovf, dut.disp_bcd_q);
    end
    chk_digits("show_9999_dp", 8'h10, 8'h90, 8'h90, 8'h90);
    strobe(5);
    wait_idle("conv_5");
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
    end
    chk_digits("show_5", 8'hFF, 8'hFF, 8'hFF, 8'h92);
  endtask

  task automatic test_back_to_back();
    bit saw22;
    saw22 = 1'b0;
    strobe(11);                      // edge k
    repeat (2) tick();
    strobe(22);                      // edge k+3
    repeat (2) tick();
    strobe(33);                      // edge k+6
    for (int c = 7; c <= 14; c++) tick();
    tests++;
    if (dut.disp_bcd_q !== 16'h0005) begin
      fails++;
      $display("FAIL b2b_pre: disp=%h expected 0005 at k+14", dut.disp_bcd_q);
    end
    tick();                          // k+15
    tests++;
    if (dut.disp_bcd_q !== 16'h0011 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: disp=%h busy=%b expected 0011 1 at k+15", dut.disp_bcd_q, busy);
    end
    for (int c = 16; c <= 29; c++) begin
      tick();
      if (dut.disp_bcd_q === 16'h0022) saw22 = 1'b1;
    end
    tests++;
    if (dut.disp_bcd_q !== 16'h0011 || saw22) begin
      fails++;
      $display("FAIL b2b_hold: disp=%h saw22=%0d expected 0011 0 at k+29", dut.disp_bcd_q, saw22);
    end
    tick();                          // k+30
    tests++;
    if (dut.disp_bcd_q !== 16'h0033 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_final: disp=%h busy=%b expected 0033 0 at k+30", dut.disp_bcd_q, busy);
    end
    tick();
    chk_digits("show_33", 8'hFF, 8'hFF, 8'hB0, 8'hB0);
  endtask

  task automatic test_reset_abort();
    bit saw;
    saw = 1'b0;
    strobe(4321);                    // edge k
    repeat (6) tick();               // through k+6
    rst_btn = 1'b0;
    tick();                          // edge k+7 in reset
    tests++;
    if (busy !== 1'b0 || dut.disp_bcd_q !== 16'h0000 || AN !== 4'hF || SEG !== 8'hFF) begin
      fails++;
      $display("FAIL abort_reset: busy=%b disp=%h AN=%b SEG=%h expected 0 0000 1111 FF", busy, dut.disp_bcd_q, AN, SEG);
    end
    rst_btn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (dut.disp_bcd_q === 16'h4321 || busy !== 1'b0) saw = 1'b1;
    end
    tests++;
    if (saw) begin
      fails++;
      $display("FAIL abort_no_4321: disp=%h busy=%b expected 0000 0", dut.disp_bcd_q, busy);
    end
    chk_digits("abort_zero", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_blanking();
    test_saturate();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
